div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 50 +++++
 rtl/div_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
//   Shared definitions for the multi-cycle integer divider controller.
//   - FSM state encoding (2-bit)
//   - ready / start handshake encodings
//   - data and result widths
//   - small two's-complement helpers used when the divider is set up and
//     when its result is finalized
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

  // Operand and result widths. The result packs {remainder, quotient}.
  localparam int unsigned DIV_DATA_W   = 32;
  localparam int unsigned DIV_RESULT_W = 64;

  // Number of restoring-division iterations (one quotient bit per cycle).
  localparam logic [5:0] DIV_ITERS = 6'd32;

  // Handshake encodings.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Divider controller states.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Two's-complement negation of a 32-bit value.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Magnitude of an operand: only negative values of a signed operation are
  // flipped. 0x80000000 maps onto itself, which the unsigned datapath then
  // treats as +2^31, so the most negative dividend needs no special case.
  function automatic logic [31:0] abs_op(input logic [31:0] op,
                                         input logic        is_signed);
    if (is_signed && op[31]) begin
      return neg32(op);
    end else begin
      return op;
    end
  endfunction

endpackage : div_ctrl_pkg

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//   Multi-cycle 32-bit signed/unsigned divider for the EX stage. Works on
//   operand magnitudes with a restoring shift/subtract loop (one quotient bit
//   per clock), then fixes up the signs of the quotient and remainder.
//
// Ports
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   signed_div_i  in   1   1 = DIV (signed), 0 = DIVU
//   opdata1_i     in   32  dividend
//   opdata2_i     in   32  divisor
//   start_i       in   1   division request, held until ready_o is seen
//   annul_i       in   1   cancel the in-flight division (flush/exception)
//   result_o      out  64  {remainder, quotient}, registered
//   ready_o       out  1   result_o valid, registered
//   stallreq_o    out  1   stall request, combinational
// -----------------------------------------------------------------------------
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [DIV_DATA_W-1:0]   opdata1_i,
  input  logic [DIV_DATA_W-1:0]   opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DIV_RESULT_W-1:0] result_o,
  output logic                    ready_o,
  output logic                    stallreq_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // dividend_q layout while iterating:
  //   [64:33] partial remainder
  //   [31:0]  remaining dividend bits shifted up, quotient bits shifted in
  // After finalization it holds {remainder, 1'b0, quotient}.
  div_state_e        state_q,    state_d;
  logic [5:0]        cnt_q,      cnt_d;
  logic [64:0]       dividend_q, dividend_d;
  logic [31:0]       divisor_q,  divisor_d;
  logic              sign_q,     sign_d;
  logic              op1_msb_q,  op1_msb_d;
  logic              op2_msb_q,  op2_msb_d;
  logic [63:0]       result_q,   result_d;
  logic              ready_q,    ready_d;

  // Datapath intermediates
  logic [32:0]       trial_diff;
  logic [31:0]       quot_fix;
  logic [31:0]       rem_fix;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // 33-bit trial subtraction; bit 32 set means the divisor did not fit.
  always_comb begin
    trial_diff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
  end

  // Sign fix-up of the unsigned quotient/remainder produced by the loop.
  // Quotient is negative when the operand signs differ; the remainder takes
  // the sign of the dividend (truncating division).
  always_comb begin
    quot_fix = dividend_q[31:0];
    rem_fix  = dividend_q[64:33];
    if (sign_q && (op1_msb_q ^ op2_msb_q)) begin
      quot_fix = neg32(dividend_q[31:0]);
    end else begin
      quot_fix = dividend_q[31:0];
    end
    if (sign_q && op1_msb_q) begin
      rem_fix = neg32(dividend_q[64:33]);
    end else begin
      rem_fix = dividend_q[64:33];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and register next values
  // ---------------------------------------------------------------------------

  // Controller sequencing: accept, iterate, finalize, hold result.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sign_d     = sign_q;
    op1_msb_d  = op1_msb_q;
    op2_msb_d  = op2_msb_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DivFree: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = 64'd0;
        if ((start_i == DIV_START) && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = DivByZero;
          end else begin
            // Operands are captured here so later changes on the inputs
            // cannot disturb the running division.
            state_d    = DivOn;
            cnt_d      = 6'd0;
            dividend_d = {32'd0, abs_op(opdata1_i, signed_div_i), 1'b0};
            divisor_d  = abs_op(opdata2_i, signed_div_i);
            sign_d     = signed_div_i;
            op1_msb_d  = opdata1_i[31];
            op2_msb_d  = opdata2_i[31];
          end
        end else begin
          state_d = DivFree;
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          dividend_d = 65'd0;
          state_d    = DivEnd;
        end
      end

      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
          cnt_d   = 6'd0;
        end else if (cnt_q != DIV_ITERS) begin
          if (trial_diff[32]) begin
            // Divisor does not fit: shift in a 0 quotient bit.
            dividend_d = {dividend_q[63:0], 1'b0};
          end else begin
            // Divisor fits: keep the difference, shift in a 1 quotient bit.
            dividend_d = {trial_diff[31:0], dividend_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          dividend_d = {rem_fix, 1'b0, quot_fix};
          cnt_d      = 6'd0;
          state_d    = DivEnd;
        end
      end

      DivEnd: begin
        // Result is presented while the requester keeps start_i high; once it
        // lets go the outputs clear and the divider becomes free again.
        if (start_i == DIV_START) begin
          ready_d  = DIV_RESULT_READY;
          result_d = {dividend_q[64:33], dividend_q[31:0]};
        end else begin
          state_d  = DivFree;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = 64'd0;
        end
      end

      default: begin
        state_d  = DivFree;
        cnt_d    = 6'd0;
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = 64'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= 6'd0;
      dividend_q <= 65'd0;
      divisor_q  <= 32'd0;
      sign_q     <= 1'b0;
      op1_msb_q  <= 1'b0;
      op2_msb_q  <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sign_q     <= sign_d;
      op1_msb_q  <= op1_msb_d;
      op2_msb_q  <= op2_msb_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign result_o   = result_q;
  assign ready_o    = ready_q;
  // Stall while a request is pending and no result has been presented yet.
  assign stallreq_o = start_i & ~annul_i & ~ready_q;

endmodule : div_ctrl
